// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier with N-cycle fixed latency.
// Define SEQ_MULT_SIGNED_EN to add the signed_mode port for two's-complement operands.
module seq_shift_add_multiplier #(
    parameter int M = 8,
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M+N-1:0] product,
    output logic           busy
`ifdef SEQ_MULT_SIGNED_EN
    ,
    input  logic           signed_mode
`endif
);

    localparam int W  = M + N;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [1:0]    r_state;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_a_sh;
    logic [N-1:0]  r_b_sh;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_product;
    logic          r_neg;

    logic          w_accept;
    logic          w_release;
    logic          w_last;
    logic [W-1:0]  w_sum;
    logic [W-1:0]  w_result;
    logic [M-1:0]  w_a_mag;
    logic [N-1:0]  w_b_mag;
    logic          w_neg;

`ifdef SEQ_MULT_SIGNED_EN
    // Magnitude of the most negative value wraps to 2^(M-1), which is correct as unsigned.
    assign w_a_mag = (signed_mode && a[M-1]) ? (~a + 1'b1) : a;
    assign w_b_mag = (signed_mode && b[N-1]) ? (~b + 1'b1) : b;
    assign w_neg   = signed_mode && (a[M-1] ^ b[N-1]);
`else
    assign w_a_mag = a;
    assign w_b_mag = b;
    assign w_neg   = 1'b0;
`endif

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_release = out_ready && (r_state == S_DONE);
    assign w_last    = (r_cnt == CNT_LAST);
    assign w_sum     = r_acc + (r_b_sh[0] ? r_a_sh : '0);
    assign w_result  = r_neg ? ('0 - w_sum) : w_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) r_state <= S_RUN;
                S_RUN:   if (w_last) r_state <= S_DONE;
                S_DONE:  if (w_release) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Every RUN edge iterates, even with a zero multiplier, to keep latency fixed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_cnt  <= '0;
            r_neg  <= 1'b0;
        end else if (w_accept) begin
            r_acc  <= '0;
            r_a_sh <= {{N{1'b0}}, w_a_mag};
            r_b_sh <= w_b_mag;
            r_cnt  <= '0;
            r_neg  <= w_neg;
        end else if (r_state == S_RUN) begin
            r_acc  <= w_sum;
            r_a_sh <= r_a_sh << 1;
            r_b_sh <= r_b_sh >> 1;
            r_cnt  <= r_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_product <= '0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_product <= w_result;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign product   = r_product;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Randomized self-checking bench for seq_shift_add_multiplier.
// Covers M=N=8 plus an M=16/N=4 instance; signed cases need SEQ_MULT_SIGNED_EN.
module tb_seq_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] product;
    logic        busy;
    logic        sm = 1'b0;

    logic        v16 = 1'b0;
    logic        rdy16;
    logic [15:0] a16 = '0;
    logic [3:0]  b16 = '0;
    logic        ov16;
    logic        or16 = 1'b0;
    logic [19:0] p16;
    logic        busy16;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_shift_add_multiplier #(.M(8), .N(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a8), .b(b8),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
`ifdef SEQ_MULT_SIGNED_EN
        , .signed_mode(sm)
`endif
    );

    seq_shift_add_multiplier #(.M(16), .N(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v16), .in_ready(rdy16),
        .a(a16), .b(b16),
        .out_valid(ov16), .out_ready(or16),
        .product(p16), .busy(busy16)
`ifdef SEQ_MULT_SIGNED_EN
        , .signed_mode(1'b0)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] x,
                                         input logic [7:0] y,
                                         input logic s);
        longint px, py;
        px = s ? longint'($signed(x)) : longint'(x);
        py = s ? longint'($signed(y)) : longint'(y);
        return 16'(px * py);
    endfunction

    task automatic run8(input logic [7:0] xa, input logic [7:0] xb,
                        input logic xs, input int hold, input bit noise);
        logic [15:0] exp;
        int n;
        exp = ref8(xa, xb, xs);
        @(negedge clk);
        check("idle_ready", in_ready, 1);
        a8 = xa; b8 = xb; sm = xs; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            check("busy_run", busy, 1);
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                a8 = 8'($urandom); b8 = 8'($urandom); sm = 1'($urandom);
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("latency", n, 8);
        check("product", product, exp);
        check("busy_done", busy, 1);
        check("ready_done", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_product", product, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("released", out_valid, 0);
        check("ready_again", in_ready, 1);
        check("busy_idle", busy, 0);
        check("product_kept", product, exp);
    endtask

    task automatic run16(input logic [15:0] xa, input logic [3:0] xb);
        logic [19:0] exp;
        int n;
        exp = 20'(longint'(xa) * longint'(xb));
        @(negedge clk);
        a16 = xa; b16 = xb; v16 = 1'b1;
        @(negedge clk);
        v16 = 1'b0;
        n = 0;
        while (!ov16 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("lat16", n, 4);
        check("prod16", p16, exp);
        or16 = 1'b1;
        @(negedge clk);
        or16 = 1'b0;
        check("ready16", rdy16, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        #12;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_product", product, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run8(8'd12, 8'd63, 1'b0, 0, 0);
        run8(8'd255, 8'd255, 1'b0, 5, 0);
        run8(8'd7, 8'd9, 1'b0, 1, 1);
        run8(8'd0, 8'd200, 1'b0, 0, 0);
        run8(8'd200, 8'd0, 1'b0, 0, 0);
        run8(8'd1, 8'd128, 1'b0, 0, 0);

        // Reset in the middle of an operation.
        @(negedge clk);
        a8 = 8'd100; b8 = 8'd200; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", in_ready, 1);
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_product", product, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_pulse", seen, 0);
        run8(8'd3, 8'd5, 1'b0, 0, 0);

`ifdef SEQ_MULT_SIGNED_EN
        run8(8'h80, 8'h80, 1'b1, 0, 0);
        run8(8'hFD, 8'd5, 1'b1, 0, 0);
        run8(8'd0, 8'hFF, 1'b1, 0, 0);
        run8(8'hFD, 8'd5, 1'b0, 0, 0);
`endif

        for (int i = 0; i < 20; i++) begin
            logic s;
`ifdef SEQ_MULT_SIGNED_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            run8(8'($urandom), 8'($urandom), s,
                 int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        run16(16'hFFFF, 4'hF);
        run16(16'd1234, 4'd9);
        run16(16'd0, 4'd7);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_shift_add_multiplier.md
SEQ_SHIFT_ADD_MULTIPLIER -- requirements
Module: seq_shift_add_multiplier

Interface
REQ-001 Parameter M, default 8: width of multiplicand a, with legal range 2..32.
REQ-002 Parameter N, default 8: width of multiplier b, which also sets the iteration count, with legal range 2..32.
REQ-003 The port list SHALL be, clock and reset first, one line per port:
- clk  input  1  single clock; rising edge active.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept operands.
- a  input  M  multiplicand.
- b  input  N  multiplier.
- out_valid  output  1  product is valid and held.
- out_ready  input  1  consumer accepts the product.
- product  output  M+N  result.
- busy  output  1  high in RUN or DONE.
REQ-004 When SEQ_MULT_SIGNED_EN is defined, the block SHALL add port signed_mode (input, 1 bit), which selects two's-complement operands.

Function
REQ-005 The FSM SHALL have three states, IDLE, RUN and DONE, encoded in 2 bits.
REQ-006 IDLE SHALL drive in_ready=1, out_valid=0 and busy=0.
REQ-007 On an edge where in_valid&&in_ready, the block SHALL register a into a shift register of width M+N (zero-extended) and b into a shift register of width N, clear the accumulator and the counter, and go to RUN.
REQ-008 In RUN, on each edge: if b_sh[0]==1 then acc<=acc+a_sh; a_sh shifts left by 1; b_sh shifts right by 1; cnt increments.
REQ-009 The accumulator addition SHALL be modulo 2^(M+N), and no operand combination may overflow it.
REQ-010 After exactly N RUN edges the FSM SHALL go to DONE, so out_valid rises N cycles after the accept edge.
REQ-011 The block SHALL NOT skip iterations when b_sh==0, so latency is fixed at N.
REQ-012 The cnt width SHALL be $clog2(N+1) bits, and it SHALL never wrap within one operation.
REQ-013 DONE SHALL drive out_valid=1 and in_ready=0, and product SHALL stay stable until out_ready is sampled high.
REQ-014 On an edge where out_valid&&out_ready, the FSM SHALL go to IDLE, product SHALL keep its last value, and the next accept SHALL be possible no earlier than the following edge.
REQ-015 in_valid seen outside IDLE SHALL be ignored, and a, b and signed_mode seen outside the accept edge SHALL have no effect.
REQ-016 The outputs SHALL be registered or decoded from state only, with no combinational path from any input to any output.
REQ-017 Boundary cases: a=0 or b=0 gives product=0; a=2^M-1 with b=2^N-1 gives product (2^M-1)(2^N-1), and these results are unsigned.

Reset
REQ-018 When rst_n is low, the block SHALL asynchronously force state=IDLE, acc=0, a_sh=0, b_sh=0, cnt=0, product=0, out_valid=0, busy=0 and in_ready=1.
REQ-019 If reset is asserted during RUN or DONE, the block SHALL abort the operation with no output pulse; after rst_n deasserts, the first rising edge may accept new operands.

Configuration
REQ-020 Macro SEQ_MULT_SIGNED_EN defined:
- signed_mode is sampled on the accept edge.
- When signed_mode=1, a and b are converted to magnitudes and neg=a[M-1]^b[N-1] is stored.
- On the RUN->DONE edge, product is loaded with -acc when neg=1 and with acc otherwise.
- Latency stays N.
REQ-021 With SEQ_MULT_SIGNED_EN defined and signed_mode=1, the magnitude of -2^(M-1) SHALL be 2^(M-1) in M unsigned bits, and (-2^(M-1))*(-2^(N-1)) SHALL give +2^(M+N-2).
REQ-022 With SEQ_MULT_SIGNED_EN defined and signed_mode=0, behaviour SHALL be identical to the unsigned build.
REQ-023 Macro SEQ_MULT_SIGNED_EN undefined: signed_mode does not exist, and all operands are unsigned.

Verification (M=N=8 unless noted)
REQ-024 Accept a=12, b=63 at edge t -> out_valid rises at edge t+8 with product=756, and busy is high over t+1..t+8.
REQ-025 a=255, b=255 with out_ready held low for 5 cycles -> product=65025 stays stable and out_valid stays high; one cycle of out_ready -> the FSM returns to IDLE and in_ready=1.
REQ-026 in_valid asserted during RUN with different operands -> those operands are ignored and the first result is correct (a=7, b=9 -> 63).
REQ-027 rst_n pulsed low at RUN cycle 4 -> outputs go to reset values immediately, no out_valid appears, and the next operation a=3, b=5 -> 15.
REQ-028 With SEQ_MULT_SIGNED_EN defined and signed_mode=1: a=-128 and b=-128 -> 16384; a=-3 and b=5 -> 0xFFF1; a=0 and b=-1 -> 0.
REQ-029 With M=16 and N=4, a=65535 and b=15 -> product=983025 after 4 cycles.
